// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state type and default parameters for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, ERR} hz_state_e;
  localparam int AW_DEF = 5;
  localparam int MEM_TIMEOUT_DEF = 16;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: data-memory req/ack FSM with a stall timeout that reports a bus error
//   in : clk, reset (sync, active-high), acc (MW load/store), mem_ack
//   out: mem_req, stall (combinational), mem_err (registered one-cycle pulse, high in ERR)
module mem_wait_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic acc,
  input  logic mem_ack,
  output logic mem_req,
  output logic stall,
  output logic mem_err
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  hz_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mem_err_q, mem_err_d;
  // cnt_q holds the number of stall cycles already spent on the current access
  always_comb begin
    mem_req = (state_q != ERR) & acc;
    stall = mem_req & ~mem_ack;
    state_d = state_q;
    cnt_d = cnt_q;
    mem_err_d = 1'b0;
    case (state_q)
      IDLE: if (stall) begin
        state_d = WAIT_MEM;
        cnt_d = CW'(1);
      end
      WAIT_MEM: if (mem_ack) begin
        state_d = IDLE;
        cnt_d = '0;
      end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
        state_d = ERR;
        cnt_d = '0;
        mem_err_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end
  assign mem_err = mem_err_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding controller for the IF|DE|MW pipeline
//   in : clk, reset (sync, active-high), reg_wrMW, rd_addrMW, rs1/rs2_addrDE, rs1/rs2_usedDE,
//        rd_enMW, wr_enMW, mem_ack, br_takenDE
//   out: mem_req, stall, flush, fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt
//   HAZ_PERF_CNT_EN: when defined, saturating stall/flush counters; otherwise both read 0
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W = 32,
  parameter int AW = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_wrMW,
  input  logic [AW-1:0]    rd_addrMW,
  input  logic [AW-1:0]    rs1_addrDE,
  input  logic [AW-1:0]    rs2_addrDE,
  input  logic             rs1_usedDE,
  input  logic             rs2_usedDE,
  input  logic             rd_enMW,
  input  logic             wr_enMW,
  input  logic             mem_ack,
  input  logic             br_takenDE,
  output logic             mem_req,
  output logic             stall,
  output logic             flush,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic wb_ok;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk),
    .reset(reset),
    .acc(rd_enMW | wr_enMW),
    .mem_ack(mem_ack),
    .mem_req(mem_req),
    .stall(stall),
    .mem_err(mem_err)
  );
  always_comb begin
    wb_ok = reg_wrMW & (rd_addrMW != '0);
    fwd_a = wb_ok & (rd_addrMW == rs1_addrDE) & rs1_usedDE;
    fwd_b = wb_ok & (rd_addrMW == rs2_addrDE) & rs2_usedDE;
    flush = br_takenDE & ~stall;
  end
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flush && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks of pipeline_hazard_ctrl against a streak-count model
module tb_pipeline_hazard_ctrl;
  localparam int MT = 4;
  localparam int CW = 8;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reg_wrMW = 1'b0, rs1_usedDE = 1'b0, rs2_usedDE = 1'b0;
  logic rd_enMW = 1'b0, wr_enMW = 1'b0, mem_ack = 1'b0, br_takenDE = 1'b0;
  logic [AW-1:0] rd_addrMW = '0, rs1_addrDE = '0, rs2_addrDE = '0;
  logic mem_req, stall, flush, fwd_a, fwd_b, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int errors = 0, checks = 0;
  bit m_err = 0;
  int m_streak = 0, m_scnt = 0, m_fcnt = 0;
  bit last_stall = 0;
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .reg_wrMW(reg_wrMW), .rd_addrMW(rd_addrMW),
    .rs1_addrDE(rs1_addrDE), .rs2_addrDE(rs2_addrDE), .rs1_usedDE(rs1_usedDE),
    .rs2_usedDE(rs2_usedDE), .rd_enMW(rd_enMW), .wr_enMW(wr_enMW), .mem_ack(mem_ack),
    .br_takenDE(br_takenDE), .mem_req(mem_req), .stall(stall), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // Model: an access in MW stalls until acked; after MT consecutive stall cycles
  // one error cycle follows in which the access is forced to retire.
  always @(negedge clk) begin
    logic acc, e_req, e_stall, e_flush, e_fa, e_fb;
    acc = rd_enMW | wr_enMW;
    e_req = !m_err && acc;
    e_stall = e_req && !mem_ack;
    e_flush = br_takenDE && !e_stall;
    e_fa = reg_wrMW && rd_addrMW != 0 && rd_addrMW == rs1_addrDE && rs1_usedDE;
    e_fb = reg_wrMW && rd_addrMW != 0 && rd_addrMW == rs2_addrDE && rs2_usedDE;
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("fwd_a", 32'(fwd_a), 32'(e_fa));
    chk("fwd_b", 32'(fwd_b), 32'(e_fb));
    chk("mem_err", 32'(mem_err), 32'(m_err));
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
`else
    chk("stall_cnt", 32'(stall_cnt), 32'(0));
    chk("flush_cnt", 32'(flush_cnt), 32'(0));
`endif
    last_stall = e_stall;
    if (reset) begin
      m_err = 0;
      m_streak = 0;
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
      if (e_stall && m_scnt < (1 << CW) - 1) m_scnt++;
      if (e_flush && m_fcnt < (1 << CW) - 1) m_fcnt++;
      if (m_err) begin
        m_err = 0;
        m_streak = 0;
      end else if (e_stall) begin
        m_streak++;
        if (m_streak == MT) begin
          m_err = 1;
          m_streak = 0;
        end
      end else m_streak = 0;
    end
  end
  initial begin
    int pct;
    cyc();
    cyc();
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_req", 32'(mem_req), 32'(0));
    chk("rst_err", 32'(mem_err), 32'(0));
    chk("rst_scnt", 32'(stall_cnt), 32'(0));
    reset = 0;
    reg_wrMW = 1; rd_addrMW = 5; rs1_addrDE = 5; rs2_addrDE = 5; rs1_usedDE = 1; rs2_usedDE = 1;
    #1;
    chk("fwd5_a", 32'(fwd_a), 32'(1));
    chk("fwd5_b", 32'(fwd_b), 32'(1));
    cyc();
    rd_addrMW = 0; rs1_addrDE = 0; rs2_addrDE = 0;
    #1;
    chk("fwd0_a", 32'(fwd_a), 32'(0));
    chk("fwd0_b", 32'(fwd_b), 32'(0));
    cyc();
    reg_wrMW = 0; rd_enMW = 1; mem_ack = 1;
    #1;
    chk("zw_req", 32'(mem_req), 32'(1));
    chk("zw_stall", 32'(stall), 32'(0));
    cyc();
    rd_enMW = 0; wr_enMW = 1; mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st3_stall", 32'(stall), 32'(1));
      cyc();
    end
    mem_ack = 1;
    #1;
    chk("st3_ack", 32'(stall), 32'(0));
    cyc();
    mem_ack = 0;
    for (int i = 0; i < MT; i++) begin
      #1;
      chk("to_stall", 32'(stall), 32'(1));
      cyc();
    end
    mem_ack = 1; br_takenDE = 1;
    #1;
    chk("err_pulse", 32'(mem_err), 32'(1));
    chk("err_stall", 32'(stall), 32'(0));
    chk("err_req", 32'(mem_req), 32'(0));
    chk("err_flush", 32'(flush), 32'(1));
    cyc();
    wr_enMW = 0; mem_ack = 0; br_takenDE = 0;
    #1;
    chk("err_done", 32'(mem_err), 32'(0));
    cyc();
    rd_enMW = 1; br_takenDE = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("br_hold", 32'(flush), 32'(0));
      cyc();
    end
    mem_ack = 1;
    #1;
    chk("br_flush", 32'(flush), 32'(1));
    cyc();
    br_takenDE = 0; mem_ack = 0;
    cyc();
    reset = 1;
    #1;
    chk("rw_stall", 32'(stall), 32'(1));
    cyc();
    reset = 0; rd_enMW = 0;
    #1;
    chk("rw_req", 32'(mem_req), 32'(0));
    chk("rw_err", 32'(mem_err), 32'(0));
`ifdef HAZ_PERF_CNT_EN
    chk("rw_scnt", 32'(stall_cnt), 32'(0));
`endif
    cyc();
    wr_enMW = 1;
    for (int i = 0; i < MT; i++) begin
      #1;
      chk("fresh_stall", 32'(stall), 32'(1));
      cyc();
    end
    #1;
    chk("fresh_err", 32'(mem_err), 32'(1));
    wr_enMW = 0;
    pct = 40;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (n % 200 == 0) pct = (n / 200) % 3 == 0 ? 10 : (n / 200) % 3 == 1 ? 40 : 90;
      reset = $urandom_range(99) < 2;
      if (!last_stall) begin
        int r;
        r = $urandom_range(3);
        rd_enMW = r == 1;
        wr_enMW = r == 2;
      end
      mem_ack = $urandom_range(99) < pct;
      br_takenDE = $urandom_range(3) == 0;
      reg_wrMW = $urandom_range(1) == 1;
      rd_addrMW = AW'($urandom_range(3));
      rs1_addrDE = AW'($urandom_range(3));
      rs2_addrDE = AW'($urandom_range(3));
      rs1_usedDE = $urandom_range(1) == 1;
      rs2_usedDE = $urandom_range(1) == 1;
    end
    cyc();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 3-stage (IF | DE | MW) pipeline. It produces the single `stall` that freezes the PC, IF/DE and MW pipeline registers. It also produces `flush`, which kills the IF/DE instruction on a taken branch, and the MW→DE operand forwarding selects. A small FSM runs the data-memory request/acknowledge handshake for loads and stores in MW, with a timeout that reports a bus error instead of hanging the core.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive stall cycles per memory access before an error is declared (≥2).
- CNT_W, 32: width of the performance counters.
- AW, 5: register-address width.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- reg_wrMW  in  1  MW instruction writes the register file.
- rd_addrMW  in  AW  MW destination register.
- rs1_addrDE, rs2_addrDE  in  AW  DE source registers.
- rs1_usedDE, rs2_usedDE  in  1  DE instruction actually reads rs1 / rs2.
- rd_enMW, wr_enMW  in  1  MW instruction is a load / store.
- mem_ack  in  1  data memory completes the current access this cycle.
- br_takenDE  in  1  DE resolved a taken branch or jump.
- mem_req  out  1  data-memory access request.
- stall  out  1  freezes PC, IF/DE and MW registers.
- flush  out  1  clears IF/DE to a NOP.
- fwd_a, fwd_b  out  1  select MW writeback data for operand A / B in DE.
- mem_err  out  1  one-cycle memory-timeout pulse, registered.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
- FSM states are IDLE, WAIT_MEM and ERR. Reset forces IDLE.
- `acc = rd_enMW | wr_enMW`.
- `mem_req = acc` in IDLE and WAIT_MEM, and 0 in ERR.
- `stall = mem_req & ~mem_ack`. This is combinational, so a zero-wait memory causes no stall.
- IDLE:
  - acc & ~mem_ack → WAIT_MEM.
  - Otherwise stay in IDLE.
- WAIT_MEM:
  - mem_ack → IDLE.
  - Otherwise, if this is the MEM_TIMEOUT-th consecutive stall cycle of the access → ERR.
  - Otherwise stay in WAIT_MEM.
- ERR:
  - stall = 0 and mem_req = 0, so the MW instruction retires and any mem_ack is ignored.
  - mem_err = 1.
  - Always → IDLE.
- `flush = br_takenDE & ~stall`. A branch that resolves during a stall is held in DE and flushes in the first non-stalled cycle. Flush and ERR may coincide.
- `fwd_a = reg_wrMW & (rd_addrMW != 0) & (rd_addrMW == rs1_addrDE) & rs1_usedDE`. fwd_b is the same rule using rs2. Forwarding is independent of stall.
- The wait counter is cleared on entry to IDLE.

## Timing
- Reset values:
  - IDLE.
  - mem_err = 0.
  - Wait counter = 0.
  - Both perf counters = 0.
- stall, flush, mem_req and fwd_* are combinational from the inputs and current state. All of them are 0 under reset with acc = 0.
- Access latency: an ack k cycles after the request gives exactly k stall cycles. Ack in the request cycle gives none.
- Timeout: stall is high for exactly MEM_TIMEOUT cycles, and ERR (mem_err = 1, stall = 0) occupies the next cycle.
- Back-to-back accesses: an access in MW directly after ack or ERR starts a fresh count from IDLE.
- Reset during WAIT_MEM returns to IDLE the next cycle and drops mem_req. There is no error pulse.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - stall_cnt increments on every stall cycle.
  - flush_cnt increments on every flush cycle.
  - Both saturate at all-ones and clear on reset.
- HAZ_PERF_CNT_EN undefined:
  - No counter registers.
  - stall_cnt and flush_cnt ports remain and are driven constant 0.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - `hz_state_e` enum (IDLE, WAIT_MEM, ERR).
  - AW default.
  - MEM_TIMEOUT default.
- Sub-module `mem_wait_timer` contains the FSM plus the wait counter, with a counter width of $clog2(MEM_TIMEOUT+1). It outputs mem_req, stall and mem_err.
- Forwarding, flush and perf-counter logic stay in the top module.

## Test plan
- Forward both operands: reg_wrMW = 1, rd_addrMW = 5, rs1 = rs2 = 5, both used → fwd_a = fwd_b = 1. Repeat with rd_addrMW = 0 → both 0.
- Zero-wait load: rd_enMW = 1 with mem_ack = 1 in the same cycle → mem_req = 1, stall = 0, state stays IDLE.
- Three-cycle store: wr_enMW = 1, ack 3 cycles later → stall high for exactly 3 cycles, low in the ack cycle, FSM back to IDLE.
- Timeout with MEM_TIMEOUT = 4 and no ack → stall high for 4 cycles, then one cycle of mem_err = 1, stall = 0, mem_req = 0, then IDLE. A late ack during ERR is ignored.
- Branch during stall: br_takenDE = 1 while waiting for an ack → flush = 0 until the ack cycle, then flush = 1 in that cycle.
- Reset in WAIT_MEM → next cycle IDLE, mem_req = 0, mem_err = 0. With HAZ_PERF_CNT_EN defined, stall_cnt = 0 after reset and equals total stall cycles afterwards.
